// File: rtl/univ_shreg_pkg.sv
// univ_shreg_pkg
//   Shared types for the universal shift register:
//     mode_t   - 3-bit operation select encodings
//     state_t  - control FSM states
//     MODE_W   - width of the mode field
//     is_shift - true for modes that run as a multi-step command

package univ_shreg_pkg;

    localparam int unsigned MODE_W = 3;

    typedef enum logic [MODE_W-1:0] {
        ModeHold = 3'b000,
        ModeLoad = 3'b001,
        ModeShl  = 3'b010,
        ModeShr  = 3'b011,
        ModeRol  = 3'b100,
        ModeRor  = 3'b101,
        ModeAsr  = 3'b110,
        ModeRsvd = 3'b111
    } mode_t;

    typedef enum logic [0:0] {
        StIdle = 1'b0,
        StRun  = 1'b1
    } state_t;

    function automatic logic is_shift(input mode_t m);
        return m inside {ModeShl, ModeShr, ModeRol, ModeRor, ModeAsr};
    endfunction

endpackage

// File: rtl/univ_shreg_step.sv
// univ_shreg_step
//   Combinational single-bit step of the shift register.
//   Ports:
//     t_i     - current register contents
//     mode_i  - operation (non-shift modes pass t_i through)
//     lshl_i  - serial input into bit 0 on SHL
//     rshr_i  - serial input into bit WIDTH-1 on SHR
//     t_o     - register contents after one step
//     out_o   - bit shifted or rotated out by this step

module univ_shreg_step
    import univ_shreg_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] t_i,
    input  mode_t            mode_i,
    input  logic             lshl_i,
    input  logic             rshr_i,
    output logic [WIDTH-1:0] t_o,
    output logic             out_o
);

    always_comb begin
        t_o   = t_i;
        out_o = 1'b0;
        case (mode_i)
            ModeShl: begin
                t_o   = {t_i[WIDTH-2:0], lshl_i};
                out_o = t_i[WIDTH-1];
            end
            ModeShr: begin
                t_o   = {rshr_i, t_i[WIDTH-1:1]};
                out_o = t_i[0];
            end
            ModeRol: begin
                t_o   = {t_i[WIDTH-2:0], t_i[WIDTH-1]};
                out_o = t_i[WIDTH-1];
            end
            ModeRor: begin
                t_o   = {t_i[0], t_i[WIDTH-1:1]};
                out_o = t_i[0];
            end
            ModeAsr: begin
                t_o   = {t_i[WIDTH-1], t_i[WIDTH-1:1]};
                out_o = t_i[0];
            end
            default: begin
                t_o   = t_i;
                out_o = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/univ_shift_reg.sv
// univ_shift_reg
//   Parametrised load/shift/rotate register. Multi-bit shift commands run one
//   bit per clock under a start/busy/done handshake.
//   Optional feature macro: UNIV_SHREG_PARITY_EN (adds registered parity output PAR).
//   Ports:
//     CLK    - clock, rising edge
//     Clr    - synchronous active-high reset
//     S      - parallel load data
//     LSHL   - serial input into bit 0 on SHL (sampled every step)
//     RSHR   - serial input into bit WIDTH-1 on SHR (sampled every step)
//     mode   - operation select, latched at accept
//     amount - step count, clamped to WIDTH, latched at accept
//     start  - command request, accepted when not busy
//     T      - register contents
//     SOUT   - last bit shifted/rotated out
//     busy   - steps remain after this edge
//     done   - one-cycle completion pulse
//     PAR    - even parity of T (only with UNIV_SHREG_PARITY_EN)

module univ_shift_reg
    import univ_shreg_pkg::*;
#(
    parameter  int unsigned WIDTH = 8,
    localparam int unsigned AW    = $clog2(WIDTH) + 1
) (
    input  logic             CLK,
    input  logic             Clr,
    input  logic [WIDTH-1:0] S,
    input  logic             LSHL,
    input  logic             RSHR,
    input  logic [2:0]       mode,
    input  logic [AW-1:0]    amount,
    input  logic             start,
    output logic [WIDTH-1:0] T,
    output logic             SOUT,
    output logic             busy,
    output logic             done
`ifdef UNIV_SHREG_PARITY_EN
    ,
    output logic             PAR
`endif
);

    state_t           state_q, state_d;
    logic [AW-1:0]    rem_q, rem_d;
    mode_t            mode_q, mode_d;
    logic [WIDTH-1:0] t_q, t_d;
    logic             sout_q, sout_d;
    logic             done_q, done_d;

    mode_t            cmd_mode;
    logic [AW-1:0]    n_clamp;
    mode_t            step_mode;
    logic [WIDTH-1:0] step_t;
    logic             step_out;

    assign cmd_mode = mode_t'(mode);
    assign n_clamp  = (amount > AW'(WIDTH)) ? AW'(WIDTH) : amount;

    // The first step happens on the accept edge, so it must use the live mode.
    assign step_mode = (state_q == StIdle) ? cmd_mode : mode_q;

    univ_shreg_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .t_i    (t_q),
        .mode_i (step_mode),
        .lshl_i (LSHL),
        .rshr_i (RSHR),
        .t_o    (step_t),
        .out_o  (step_out)
    );

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        mode_d  = mode_q;
        t_d     = t_q;
        sout_d  = sout_q;
        done_d  = 1'b0;
        case (state_q)
            StIdle: begin
                if (start) begin
                    mode_d = cmd_mode;
                    if (is_shift(cmd_mode)) begin
                        if (n_clamp != '0) begin
                            t_d    = step_t;
                            sout_d = step_out;
                            rem_d  = n_clamp - AW'(1);
                            if (rem_d != '0) begin
                                state_d = StRun;
                            end else begin
                                done_d = 1'b1;
                            end
                        end else begin
                            done_d = 1'b1;
                        end
                    end else begin
                        if (cmd_mode == ModeLoad) begin
                            t_d = S;
                        end
                        done_d = 1'b1;
                    end
                end
            end
            StRun: begin
                t_d    = step_t;
                sout_d = step_out;
                rem_d  = rem_q - AW'(1);
                if (rem_d == '0) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (Clr) begin
            state_q <= StIdle;
            rem_q   <= '0;
            mode_q  <= ModeHold;
            t_q     <= '0;
            sout_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            mode_q  <= mode_d;
            t_q     <= t_d;
            sout_q  <= sout_d;
            done_q  <= done_d;
        end
    end

    assign T    = t_q;
    assign SOUT = sout_q;
    assign busy = (state_q == StRun);
    assign done = done_q;

`ifdef UNIV_SHREG_PARITY_EN
    logic par_q;

    always_ff @(posedge CLK) begin
        if (Clr) begin
            par_q <= 1'b0;
        end else begin
            par_q <= ^t_d;
        end
    end

    assign PAR = par_q;
`endif

endmodule

// File: tb/tb_univ_shift_reg.sv
// tb_univ_shift_reg
//   Self-checking bench for univ_shift_reg at WIDTH=8. Expected values come
//   from closed-form arithmetic on the register value at command accept.

module tb_univ_shift_reg;

    localparam int W = 8;

    logic         CLK = 1'b0;
    logic         Clr;
    logic [7:0]   S;
    logic         LSHL;
    logic         RSHR;
    logic [2:0]   mode;
    logic [3:0]   amount;
    logic         start;
    logic [7:0]   T;
    logic         SOUT;
    logic         busy;
    logic         done;
`ifdef UNIV_SHREG_PARITY_EN
    logic         PAR;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] m_t;
    logic       m_sout;

    univ_shift_reg #(
        .WIDTH (W)
    ) dut (
        .CLK    (CLK),
        .Clr    (Clr),
        .S      (S),
        .LSHL   (LSHL),
        .RSHR   (RSHR),
        .mode   (mode),
        .amount (amount),
        .start  (start),
        .T      (T),
        .SOUT   (SOUT),
        .busy   (busy),
        .done   (done)
`ifdef UNIV_SHREG_PARITY_EN
        ,
        .PAR    (PAR)
`endif
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [7:0] et, input logic eb,
                             input logic ed, input logic es);
        check({tag, "_T"}, 64'(T), 64'(et));
        check({tag, "_busy"}, 64'(busy), 64'(eb));
        check({tag, "_done"}, 64'(done), 64'(ed));
        check({tag, "_SOUT"}, 64'(SOUT), 64'(es));
`ifdef UNIV_SHREG_PARITY_EN
        check({tag, "_PAR"}, 64'(PAR), 64'(^et));
`endif
    endtask

    // Register value after k steps of mode md from t0 (serial inputs held constant).
    function automatic logic [7:0] exp_t(input int md, input logic [7:0] t0, input int k,
                                         input bit lshl, input bit rshr);
        int t;
        int v;
        t = int'(t0);
        v = t;
        case (md)
            2: v = (t << k) | (lshl ? ((1 << k) - 1) : 0);
            3: v = (t >> k) | (rshr ? (255 & ~(255 >> k)) : 0);
            4: v = (t << k) | (t >> (W - k));
            5: v = (t >> k) | (t << (W - k));
            6: v = ((t0[7] ? t - 256 : t) >>> k);
            default: v = t;
        endcase
        return 8'(v & 255);
    endfunction

    // Bit that leaves the register on step k.
    function automatic logic exp_sout(input int md, input logic [7:0] t0, input int k);
        if (md == 2 || md == 4) return t0[W - k];
        return t0[k - 1];
    endfunction

    // Issue one command and check every cycle until its done pulse.
    // poke: pulse a LOAD start while busy; it must be ignored.
    task automatic run_cmd(input string tag, input int md, input logic [7:0] s,
                           input int amt, input bit lshl, input bit rshr, input bit poke);
        int         n;
        logic [7:0] t0;
        bit         shift;
        n     = (amt > W) ? W : amt;
        shift = (md >= 2 && md <= 6);
        t0    = m_t;
        mode   = 3'(md);
        S      = s;
        amount = 4'(amt);
        LSHL   = lshl;
        RSHR   = rshr;
        start  = 1'b1;
        tick();
        start = 1'b0;
        if (!shift || n == 0) begin
            if (md == 1) m_t = s;
            check_all(tag, m_t, 1'b0, 1'b1, m_sout);
            return;
        end
        for (int k = 1; k <= n; k++) begin
            m_t    = exp_t(md, t0, k, lshl, rshr);
            m_sout = exp_sout(md, t0, k);
            check_all(tag, m_t, (k < n), (k == n), m_sout);
            if (k < n) begin
                if (poke) begin
                    start = 1'b1;
                    mode  = 3'b001;
                    S     = 8'($urandom);
                end
                tick();
                start = 1'b0;
            end
        end
    endtask

    initial begin
        Clr    = 1'b1;
        start  = 1'b1;
        mode   = 3'b001;
        S      = 8'hFF;
        amount = '0;
        LSHL   = 1'b0;
        RSHR   = 1'b0;
        m_t    = 8'h00;
        m_sout = 1'b0;

        // Reset overrides a pending LOAD.
        tick();
        check_all("reset1", 8'h00, 1'b0, 1'b0, 1'b0);
        tick();
        check_all("reset2", 8'h00, 1'b0, 1'b0, 1'b0);
        Clr   = 1'b0;
        start = 1'b0;
        tick();
        check_all("idle", 8'h00, 1'b0, 1'b0, 1'b0);

        run_cmd("load", 1, 8'hA5, 5, 1'b0, 1'b0, 1'b0);
        check("load_const", 64'(T), 64'h A5);
        tick();
        check("load_done_drop", 64'(done), 64'd0);

        run_cmd("shl3", 2, 8'h00, 3, 1'b1, 1'b0, 1'b0);
        check("shl3_const", 64'(T), 64'h2F);
        check("shl3_sout", 64'(SOUT), 64'd1);

        run_cmd("load90", 1, 8'h90, 0, 1'b0, 1'b0, 1'b0);
        run_cmd("asr2", 6, 8'h00, 2, 1'b0, 1'b0, 1'b1);
        check("asr2_const", 64'(T), 64'hE4);
        tick();
        check("asr2_ignored", 64'(T), 64'hE4);

        run_cmd("load81", 1, 8'h81, 0, 1'b0, 1'b0, 1'b0);
        run_cmd("ror12", 5, 8'h00, 12, 1'b0, 1'b0, 1'b0);
        check("ror12_const", 64'(T), 64'h81);

        // Back-to-back random commands, each started on the previous done cycle.
        for (int i = 0; i < 60; i++) begin
            run_cmd("rand", int'($urandom_range(0, 7)), 8'($urandom),
                    int'($urandom_range(0, 15)), 1'($urandom), 1'($urandom),
                    1'($urandom));
        end

        // Reset in the middle of a SHR by 6.
        run_cmd("preload", 1, 8'hC3, 0, 1'b0, 1'b0, 1'b0);
        mode   = 3'b011;
        amount = 4'd6;
        RSHR   = 1'b1;
        start  = 1'b1;
        tick();
        start = 1'b0;
        check_all("mid1", exp_t(3, 8'hC3, 1, 1'b0, 1'b1), 1'b1, 1'b0, 1'b1);
        tick();
        check_all("mid2", exp_t(3, 8'hC3, 2, 1'b0, 1'b1), 1'b1, 1'b0, 1'b1);
        Clr = 1'b1;
        tick();
        check_all("mid_clr", 8'h00, 1'b0, 1'b0, 1'b0);
        Clr = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            check_all("mid_after", 8'h00, 1'b0, 1'b0, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
